// File: rtl/osd_uart_16550_host.sv
// Host-side 16550 register initiator: programs the UART, then polls LSR and
// moves characters to/from ready/valid streams. Option: OSD_UART_16550_HOST_IRQ_EN.
module osd_uart_16550_host #(
    parameter logic [15:0] DIVISOR       = 16'h0001,
    parameter logic [7:0]  LCR_VAL       = 8'h03,
    parameter logic [7:0]  FCR_VAL       = 8'h07,
    parameter logic [7:0]  IER_VAL       = 8'h00,
    parameter int unsigned POLL_INTERVAL = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       bus_req,
    output logic [2:0] bus_addr,
    output logic       bus_write,
    output logic [7:0] bus_wdata,
    input  logic       bus_ack,
    input  logic [7:0] bus_rdata,
    input  logic       irq,
    input  logic       tx_valid,
    input  logic [7:0] tx_char,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_char,
    input  logic       rx_ready,
    output logic       init_done
);

    localparam int CW = (POLL_INTERVAL > 0) ? $clog2(POLL_INTERVAL + 1) : 1;
    localparam logic [CW:0] PI = (CW + 1)'(POLL_INTERVAL);

`ifdef OSD_UART_16550_HOST_IRQ_EN
    localparam logic [7:0] IER_EFF = 8'h03;
`else
    localparam logic [7:0] IER_EFF = IER_VAL;
`endif

    typedef enum logic [3:0] {
        INIT_LCR_DLAB, INIT_DLL, INIT_DLM, INIT_LCR, INIT_FCR,
        INIT_IER, POLL, READ_RBR, WRITE_THR, WAIT
    } state_e;

    state_e        state_q, state_d;
    logic          req_q, req_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rx_valid_q, rx_valid_d;
    logic [7:0]    rx_char_q, rx_char_d;
    logic [7:0]    thr_q, thr_d;
    logic          init_done_q, init_done_d;

    logic          ack, pop, early, wait_done;
    logic [CW:0]   cnt_inc;
    logic [2:0]    addr_c;
    logic          write_c;
    logic [7:0]    wdata_c;

    assign ack     = req_q & bus_ack;
    assign pop     = rx_valid_q & rx_ready;
    assign cnt_inc = {1'b0, cnt_q} + (CW + 1)'(1);
    assign wait_done = (cnt_inc >= PI);

`ifdef OSD_UART_16550_HOST_IRQ_EN
    assign early = irq | tx_valid;
`else
    logic irq_unused;
    assign irq_unused = irq;
    assign early = 1'b0;
`endif

    always_comb begin
        addr_c  = 3'd0;
        write_c = 1'b0;
        wdata_c = 8'h00;
        unique case (state_q)
            INIT_LCR_DLAB: begin addr_c = 3'd3; write_c = 1'b1; wdata_c = 8'h80;           end
            INIT_DLL:      begin addr_c = 3'd0; write_c = 1'b1; wdata_c = DIVISOR[7:0];    end
            INIT_DLM:      begin addr_c = 3'd1; write_c = 1'b1; wdata_c = DIVISOR[15:8];   end
            INIT_LCR:      begin addr_c = 3'd3; write_c = 1'b1; wdata_c = LCR_VAL;         end
            INIT_FCR:      begin addr_c = 3'd2; write_c = 1'b1; wdata_c = FCR_VAL;         end
            INIT_IER:      begin addr_c = 3'd1; write_c = 1'b1; wdata_c = IER_EFF;         end
            POLL:          begin addr_c = 3'd5;                                            end
            WRITE_THR:     begin addr_c = 3'd0; write_c = 1'b1; wdata_c = thr_q;           end
            default:       begin addr_c = 3'd0;                                            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        cnt_d       = cnt_q;
        rx_char_d   = rx_char_q;
        thr_d       = thr_q;
        init_done_d = init_done_q;
        rx_valid_d  = rx_valid_q & ~pop;
        if (state_q == WAIT) begin
            cnt_d = (cnt_inc > PI) ? PI[CW-1:0] : cnt_inc[CW-1:0];
            if (wait_done || early) begin
                state_d = POLL;
                req_d   = 1'b1;
                cnt_d   = '0;
            end
        end else if (!req_q) begin
            req_d = 1'b1;
        end else if (bus_ack) begin
            req_d = 1'b0;
            case (state_q)
                INIT_LCR_DLAB: state_d = INIT_DLL;
                INIT_DLL:      state_d = INIT_DLM;
                INIT_DLM:      state_d = INIT_LCR;
                INIT_LCR:      state_d = INIT_FCR;
                INIT_FCR:      state_d = INIT_IER;
                INIT_IER: begin
                    state_d     = POLL;
                    init_done_d = 1'b1;
                end
                POLL: begin
                    // RX wins; a buffer being popped this cycle counts as empty
                    if (bus_rdata[0] && (!rx_valid_q || pop)) begin
                        state_d = READ_RBR;
                    end else if (bus_rdata[5] && tx_valid) begin
                        state_d = WRITE_THR;
                        thr_d   = tx_char;
                    end else if (POLL_INTERVAL == 0) begin
                        state_d = POLL;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end
                end
                READ_RBR: begin
                    rx_char_d  = bus_rdata;
                    rx_valid_d = 1'b1;
                    state_d    = POLL;
                end
                default: state_d = POLL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT_LCR_DLAB;
            req_q       <= 1'b0;
            cnt_q       <= '0;
            rx_valid_q  <= 1'b0;
            rx_char_q   <= 8'h00;
            thr_q       <= 8'h00;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            rx_valid_q  <= rx_valid_d;
            rx_char_q   <= rx_char_d;
            thr_q       <= thr_d;
            init_done_q <= init_done_d;
        end
    end

    assign bus_req   = req_q;
    assign bus_addr  = req_q ? addr_c : 3'd0;
    assign bus_write = req_q & write_c;
    assign bus_wdata = req_q ? wdata_c : 8'h00;
    assign tx_ready  = ack & (state_q == WRITE_THR);
    assign rx_valid  = rx_valid_q;
    assign rx_char   = rx_char_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_osd_uart_16550_host.sv
// Directed bench for osd_uart_16550_host: init order, delayed ack,
// rx/tx paths, priority, pop-on-poll and mid-transfer reset.
module tb_osd_uart_16550_host;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bus_req, bus_write, bus_ack;
    logic [2:0] bus_addr;
    logic [7:0] bus_wdata, bus_rdata;
    logic       irq = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_char = 8'h00;
    logic       tx_ready, rx_valid, init_done;
    logic [7:0] rx_char;
    logic       rx_ready = 1'b0;

    logic [7:0] lsr = 8'h00;
    logic [7:0] rbr = 8'h00;
    int         ack_delay = 0;
    int         req_cnt = 0;

    int         ncmp = 0;
    int         nmis = 0;
    int         cyc = 0;
    int         n = 0;
    logic [2:0] log_a [64];
    logic       log_w [64];
    logic [7:0] log_d [64];
    int         log_t [64];
    int         txr_cnt = 0;
    int         txr_bad = 0;
    int         unstable = 0;
    logic       preq = 1'b0;
    logic [11:0] prev = 12'h000;

    osd_uart_16550_host #(
        .DIVISOR(16'h1234),
        .LCR_VAL(8'h03),
        .FCR_VAL(8'h07),
        .IER_VAL(8'h00),
        .POLL_INTERVAL(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_write(bus_write),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .irq(irq), .tx_valid(tx_valid), .tx_char(tx_char), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_char(rx_char), .rx_ready(rx_ready),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    assign bus_ack   = bus_req && (req_cnt >= ack_delay);
    assign bus_rdata = !bus_ack ? 8'h00 :
                       (bus_addr == 3'd5) ? lsr :
                       (bus_addr == 3'd0) ? rbr : 8'h00;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!bus_req || bus_ack) req_cnt = 0;
        else req_cnt = req_cnt + 1;
    end

    always @(posedge clk) begin
        if (rst_n && bus_req && bus_ack && n < 64) begin
            log_a[n] = bus_addr;
            log_w[n] = bus_write;
            log_d[n] = bus_wdata;
            log_t[n] = cyc;
            n = n + 1;
        end
        if (tx_ready) begin
            txr_cnt = txr_cnt + 1;
            if (!(bus_req && bus_ack && bus_write && bus_addr == 3'd0))
                txr_bad = txr_bad + 1;
        end
        if (bus_req && preq && ({bus_addr, bus_write, bus_wdata} != prev))
            unstable = unstable + 1;
        preq = bus_req;
        prev = {bus_addr, bus_write, bus_wdata};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp = ncmp + 1;
        assert (obs === exp) else begin
            nmis = nmis + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int k, input int budget);
        int i;
        i = 0;
        while (n < k && i < budget) begin
            tick();
            i = i + 1;
        end
        chk("wait_budget", 32'(n >= k), 32'd1);
    endtask

    task automatic chk_log(input string tag, input int idx,
                           input logic [2:0] a, input logic w, input logic [7:0] d);
        chk(tag, 32'({log_a[idx], log_w[idx], log_d[idx]}), 32'({a, w, d}));
    endtask

    initial begin
        int k;
        int i;

        tick();
        tick();
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_bus", 32'({bus_addr, bus_write, bus_wdata}), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd0);
        rst_n = 1'b1;

        wait_n(5, 40);
        chk("init_done_before_ier", 32'(init_done), 32'd0);
        wait_n(6, 10);
        chk("init_done_after_ier", 32'(init_done), 32'd1);
        chk_log("init0", 0, 3'd3, 1'b1, 8'h80);
        chk_log("init1", 1, 3'd0, 1'b1, 8'h34);
        chk_log("init2", 2, 3'd1, 1'b1, 8'h12);
        chk_log("init3", 3, 3'd3, 1'b1, 8'h03);
        chk_log("init4", 4, 3'd2, 1'b1, 8'h07);
        chk_log("init5", 5, 3'd1, 1'b1, 8'h00);
        for (int j = 1; j < 6; j++)
            chk("init_spacing", 32'(log_t[j] - log_t[j-1]), 32'd2);
        wait_n(8, 40);
        chk_log("poll0", 6, 3'd5, 1'b0, 8'h00);
        chk_log("poll1", 7, 3'd5, 1'b0, 8'h00);
        chk("poll_after_init", 32'(log_t[6] - log_t[5]), 32'd2);
        chk("poll_interval", 32'(log_t[7] - log_t[6]), 32'd9);

        // delayed ack on INIT_DLL
        rst_n = 1'b0;
        tick();
        n = 0;
        tick();
        rst_n = 1'b1;
        wait_n(1, 20);
        ack_delay = 3;
        wait_n(2, 30);
        ack_delay = 0;
        wait_n(3, 20);
        chk_log("dly_dll", 1, 3'd0, 1'b1, 8'h34);
        chk_log("dly_dlm", 2, 3'd1, 1'b1, 8'h12);
        chk("dly_len", 32'(log_t[1] - log_t[0]), 32'd5);
        chk("dly_stable", 32'(unstable), 32'd0);
        wait_n(8, 60);

        // rx path
        k = n;
        lsr = 8'h01;
        rbr = 8'h5A;
        wait_n(k + 2, 40);
        chk_log("rx_poll", k, 3'd5, 1'b0, 8'h00);
        chk_log("rx_rbr", k + 1, 3'd0, 1'b0, 8'h00);
        chk("rx_valid", 32'(rx_valid), 32'd1);
        chk("rx_char", 32'(rx_char), 32'h5A);
        wait_n(k + 4, 40);
        chk_log("rx_full_poll_a", k + 2, 3'd5, 1'b0, 8'h00);
        chk_log("rx_full_poll_b", k + 3, 3'd5, 1'b0, 8'h00);
        chk("rx_held", 32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        lsr = 8'h00;
        tick();
        rx_ready = 1'b0;
        chk("rx_popped", 32'(rx_valid), 32'd0);

        // tx path
        k = n;
        tx_char = 8'h41;
        tx_valid = 1'b1;
        lsr = 8'h60;
        wait_n(k + 2, 40);
        tx_valid = 1'b0;
        lsr = 8'h00;
        chk_log("tx_poll", k, 3'd5, 1'b0, 8'h00);
        chk_log("tx_thr", k + 1, 3'd0, 1'b1, 8'h41);
        chk("tx_ready_cnt", 32'(txr_cnt), 32'd1);
        chk("tx_ready_at_ack", 32'(txr_bad), 32'd0);
        k = n;
        tx_char = 8'h42;
        tx_valid = 1'b1;
        wait_n(k + 2, 40);
        chk_log("tx_busy_poll_a", k, 3'd5, 1'b0, 8'h00);
        chk_log("tx_busy_poll_b", k + 1, 3'd5, 1'b0, 8'h00);
        chk("tx_busy_wait", 32'(log_t[k+1] - log_t[k]), 32'd9);
        chk("tx_busy_no_ready", 32'(txr_cnt), 32'd1);

        // rx has priority over tx
        k = n;
        lsr = 8'h61;
        rbr = 8'h77;
        wait_n(k + 4, 60);
        tx_valid = 1'b0;
        lsr = 8'h01;
        rbr = 8'h88;
        chk_log("pri_poll", k, 3'd5, 1'b0, 8'h00);
        chk_log("pri_rbr", k + 1, 3'd0, 1'b0, 8'h00);
        chk_log("pri_poll2", k + 2, 3'd5, 1'b0, 8'h00);
        chk_log("pri_thr", k + 3, 3'd0, 1'b1, 8'h42);
        chk("pri_rx_char", 32'(rx_char), 32'h77);
        chk("pri_tx_ready_cnt", 32'(txr_cnt), 32'd2);

        // pop coinciding with the poll ack frees the buffer for this DR
        i = 0;
        while (!(bus_req && bus_addr == 3'd5 && !bus_write) && i < 100) begin
            tick();
            i = i + 1;
        end
        chk("pop_poll_seen", 32'(bus_req && bus_addr == 3'd5), 32'd1);
        k = n;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        wait_n(k + 2, 20);
        lsr = 8'h00;
        chk_log("pop_rbr", k + 1, 3'd0, 1'b0, 8'h00);
        chk("pop_rx_valid", 32'(rx_valid), 32'd1);
        chk("pop_rx_char", 32'(rx_char), 32'h88);

        // reset in the middle of a THR write
        ack_delay = 20;
        lsr = 8'h20;
        tx_char = 8'h55;
        tx_valid = 1'b1;
        i = 0;
        while (!(bus_req && bus_write && bus_addr == 3'd0) && i < 200) begin
            tick();
            i = i + 1;
        end
        chk("mid_thr_seen", 32'(bus_req && bus_write && bus_addr == 3'd0), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(bus_req), 32'd0);
        chk("mid_rst_tx_ready", 32'(tx_ready), 32'd0);
        tick();
        tick();
        chk("mid_rst_no_consume", 32'(txr_cnt), 32'd2);
        chk("mid_rst_init_done", 32'(init_done), 32'd0);
        ack_delay = 0;
        lsr = 8'h00;
        tx_valid = 1'b0;
        n = 0;
        rst_n = 1'b1;
        wait_n(6, 40);
        chk_log("replay0", 0, 3'd3, 1'b1, 8'h80);
        chk_log("replay5", 5, 3'd1, 1'b1, 8'h00);
        chk("replay_init_done", 32'(init_done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
        $finish;
    end

endmodule
